// File: rtl/mips_cpu_alu_pkg.sv
// Shared types for the execute-stage ALU and iterative multiply/divide unit,
// plus the funct/opcode decode into the ALU op select.
package mips_cpu_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU   = 4'd0,
    ALU_SUBU   = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_NOR    = 4'd5,
    ALU_SLT    = 4'd6,
    ALU_SLTU   = 4'd7,
    ALU_SLL    = 4'd8,
    ALU_SRL    = 4'd9,
    ALU_SRA    = 4'd10,
    ALU_LUI    = 4'd11,
    ALU_PASS_B = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Loads/stores and anything unlisted fall back to ADDU for address generation.
  function automatic alu_op_t decode_alu_op(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_t op;
    op = ALU_ADDU;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21: op = ALU_ADDU;
        6'h22, 6'h23: op = ALU_SUBU;
        6'h24:        op = ALU_AND;
        6'h25:        op = ALU_OR;
        6'h26:        op = ALU_XOR;
        6'h27:        op = ALU_NOR;
        6'h2a:        op = ALU_SLT;
        6'h2b:        op = ALU_SLTU;
        6'h00, 6'h04: op = ALU_SLL;
        6'h02, 6'h06: op = ALU_SRL;
        6'h03, 6'h07: op = ALU_SRA;
        default:      op = ALU_ADDU;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09: op = ALU_ADDU;
        6'h0a:        op = ALU_SLT;
        6'h0b:        op = ALU_SLTU;
        6'h0c:        op = ALU_AND;
        6'h0d:        op = ALU_OR;
        6'h0e:        op = ALU_XOR;
        6'h0f:        op = ALU_LUI;
        default:      op = ALU_ADDU;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mips_cpu_md_iter.sv
// Radix-2 multiply/restoring divide: start accepted only in IDLE, busy for WIDTH+1 cycles;
// done flags the single FIX cycle in which hi_res/lo_res hold the sign-corrected result.
module mips_cpu_md_iter
  import mips_cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  md_state_t          state;
  logic [SHW-1:0]     cnt;
  logic               div_q, sign_a, sign_b;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH:0]     sum, trial;
  logic [WIDTH-1:0]   quo, rem;
  logic               is_div, is_signed, div_zero, sa_in, sb_in;
  logic [WIDTH-1:0]   ma_in, mb_in;

  // Divide by zero runs unsigned on the raw dividend so it falls out as all-ones / a.
  always_comb begin
    is_div    = (op == MD_DIV) || (op == MD_DIVU);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    div_zero  = is_div && (b == '0);
    sa_in     = is_signed && !div_zero && a[WIDTH-1];
    sb_in     = is_signed && !div_zero && b[WIDTH-1];
    ma_in     = sa_in ? -a : a;
    mb_in     = sb_in ? -b : b;
  end

  // acc = {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (div_q) begin
      acc_nxt = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state  <= MD_RUN;
            cnt    <= LAST;
            div_q  <= is_div;
            sign_a <= sa_in;
            sign_b <= sb_in;
            opnd   <= is_div ? mb_in : ma_in;
            acc    <= {{WIDTH{1'b0}}, (is_div ? ma_in : mb_in)};
          end
        end
        MD_RUN: begin
          acc <= acc_nxt;
          if (cnt == '0) state <= MD_FIX;
          else           cnt   <= cnt - SHW'(1);
        end
        MD_FIX:  state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quo    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_res = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    lo_res = div_q ? quo : prod[WIDTH-1:0];
  end

  assign busy = (state != MD_IDLE);
  assign done = (state == MD_FIX);

endmodule

// File: rtl/mips_cpu_alu_md.sv
// Execute-stage combinational ALU plus HI/LO registers fed by the iterative MD unit.
// MD results land WIDTH+1 cycles after start; start and MTHI/MTLO are dropped while md_busy.
module mips_cpu_alu_md
  import mips_cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  alu_op_t          alu_op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  input  logic             md_start,
  input  md_op_t           md_op,
  output logic             md_busy,
  output logic             md_done,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             fix;
  logic [WIDTH-1:0] hi_res, lo_res;

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADDU:   result = a + b;
      ALU_SUBU:   result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_NOR:    result = ~(a | b);
      ALU_SLT:    result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:    result = b << shamt;
      ALU_SRL:    result = b >> shamt;
      ALU_SRA:    result = $signed(b) >>> shamt;
      ALU_LUI:    result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

  mips_cpu_md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (md_op),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (fix),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // The FIX cycle is always busy, so MT writes and the MD commit never meet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= fix;
      if (fix) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (!md_busy) begin
        if (hi_we) hi <= a;
        if (lo_we) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_alu_md.sv
// Scoreboarded bench for mips_cpu_alu_md: ALU vectors, MD results and latency, ignore and abort cases.
module tb_mips_cpu_alu_md;
  import mips_cpu_alu_pkg::*;

  logic        clk, reset;
  alu_op_t     alu_op;
  logic [4:0]  shamt;
  logic [31:0] a, b, result, hi, lo;
  logic        zero, md_start, md_busy, md_done, hi_we, lo_we;
  md_op_t      md_op;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  int issue_cyc = 0;

  string       q_tag[$];
  logic [31:0] q_hi[$];
  logic [31:0] q_lo[$];

  mips_cpu_alu_md #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_op   (alu_op),
    .shamt    (shamt),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .md_start (md_start),
    .md_op    (md_op),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every md_done must retire the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && md_done) begin
      n_done++;
      if (q_hi.size() == 0) begin
        chk("spurious_done", md_done, 1'b0);
      end else begin
        string t;
        logic [31:0] eh, el;
        t  = q_tag.pop_front();
        eh = q_hi.pop_front();
        el = q_lo.pop_front();
        chk({t, "_hi"}, hi, eh);
        chk({t, "_lo"}, lo, el);
      end
    end
  end

  task automatic alu_vec(input string tag, input alu_op_t op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [4:0] sh, input logic [31:0] exp);
    alu_op = op; a = va; b = vb; shamt = sh;
    #1;
    chk(tag, result, exp);
    chk({tag, "_zero"}, zero, (exp == 32'h0));
  endtask

  task automatic md_issue(input string tag, input md_op_t op, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit push);
    @(negedge clk);
    md_op = op; a = va; b = vb; md_start = 1'b1;
    if (push) begin
      q_tag.push_back(tag);
      q_hi.push_back(ehi);
      q_lo.push_back(elo);
    end
    issue_cyc = cyc;
    @(negedge clk);
    md_start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({tag, "_busy"}, md_busy, 1'b1);
  endtask

  task automatic md_wait(input string tag);
    int n;
    n = 0;
    while (!md_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, md_done, 1'b1);
    chk({tag, "_latency"}, cyc - issue_cyc - 1, 33);
    chk({tag, "_idle"}, md_busy, 1'b0);
  endtask

  task automatic md_run(input string tag, input md_op_t op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
    md_issue(tag, op, va, vb, ehi, elo, 1'b1);
    md_wait(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    reset = 1'b1; alu_op = ALU_ADDU; shamt = '0; a = '0; b = '0;
    md_start = 1'b0; md_op = MD_MULT; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_done", md_done, 1'b0);
    reset = 1'b0;

    alu_vec("sra",     ALU_SRA,    32'h0,          32'h8000_00F0, 5'd4,  32'hF800_000F);
    alu_vec("slt",     ALU_SLT,    32'hFFFF_FFFF,  32'h1,         5'd0,  32'h1);
    alu_vec("sltu",    ALU_SLTU,   32'hFFFF_FFFF,  32'h1,         5'd0,  32'h0);
    alu_vec("sltu_lt", ALU_SLTU,   32'h1,          32'hFFFF_FFFF, 5'd0,  32'h1);
    alu_vec("addu",    ALU_ADDU,   32'hFFFF_FFFF,  32'h1,         5'd0,  32'h0);
    alu_vec("subu",    ALU_SUBU,   32'd5,          32'd7,         5'd0,  32'hFFFF_FFFE);
    alu_vec("and",     ALU_AND,    32'hF0F0_F0F0,  32'hFF00_FF00, 5'd0,  32'hF000_F000);
    alu_vec("or",      ALU_OR,     32'hF0F0_F0F0,  32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0);
    alu_vec("xor",     ALU_XOR,    32'hF0F0_F0F0,  32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0);
    alu_vec("nor",     ALU_NOR,    32'hF0F0_F0F0,  32'hFF00_FF00, 5'd0,  32'h000F_000F);
    alu_vec("sll",     ALU_SLL,    32'hFFFF_FFFF,  32'h1,         5'd31, 32'h8000_0000);
    alu_vec("srl",     ALU_SRL,    32'hFFFF_FFFF,  32'h8000_0000, 5'd31, 32'h1);
    alu_vec("sra31",   ALU_SRA,    32'h0,          32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    alu_vec("lui",     ALU_LUI,    32'h0,          32'hABCD_1234, 5'd0,  32'h1234_0000);
    alu_vec("pass_b",  ALU_PASS_B, 32'h1,          32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    alu_vec("undef",   alu_op_t'(4'd15), 32'h5,    32'h7,         5'd3,  32'h0);

    @(negedge clk);
    a = 32'h1111_2222; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1111_2222);
    a = 32'h3333_4444; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h3333_4444);
    chk("mtlo_hi_kept", hi, 32'h1111_2222);

    md_run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    md_run("mult_neg",  MD_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md_run("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    md_run("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
    md_run("divu_zero", MD_DIVU,  32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF);
    md_run("div_zero",  MD_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    md_run("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

    // MT write alongside an accepted start lands first, then the product overwrites it.
    hi_we = 1'b1; lo_we = 1'b1;
    md_issue("mt_start", MD_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b1);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_start_hi_early", hi, 32'd2);
    chk("mt_start_lo_early", lo, 32'd2);
    md_wait("mt_start");

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_hi", hi, 32'h0);
    chk("rst2_lo", lo, 32'h0);

    n0 = n_done;
    md_issue("ign", MD_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1'b1);
    repeat (4) @(negedge clk);
    md_op = MD_DIVU; a = 32'hDEAD; b = 32'd1;
    md_start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk);
    md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("ign_mt_hi", hi, 32'h0);
    md_wait("ign");
    repeat (45) @(negedge clk);
    chk("ign_one_done", n_done - n0, 1);

    md_issue("abort", MD_DIVU, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", md_busy, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_done", md_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_hi_after", hi, 32'h0);
    chk("abort_lo_after", lo, 32'h0);

    md_run("divu_9_4", MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

    @(negedge clk);
    chk("sb_empty", q_hi.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cpu_alu_md.md
Name: mips_cpu_alu_md

Overview:
- Parametrised successor to the single-cycle 32-bit ALU. It keeps a combinational integer datapath, using a decoded op code instead of raw opcode/funct.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, covering MIPS MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Sits in the execute stage. The control FSM stalls the core on md_busy.

Parameters:
- WIDTH, 32, datapath width in bits; must be even and >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alu_op  in  4  combinational op select (alu_op_t): ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, PASS_B
- shamt  in  SHW  shift amount for SLL/SRL/SRA (callers pass rs[SHW-1:0] for variable shifts)
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt or extended immediate; extension done by decoder)
- result  out  WIDTH  combinational ALU result
- zero  out  1  result == 0
- md_start  in  1  start a multiply/divide; sampled when md_busy == 0
- md_op  in  2  md_op_t: MULT, MULTU, DIV, DIVU
- md_busy  out  1  operation in progress
- md_done  out  1  one-cycle pulse when HI/LO take the new result
- hi_we  in  1  MTHI: HI <= a
- lo_we  in  1  MTLO: LO <= a
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Combinational path: result and zero depend only on alu_op, shamt, a, b (no register).
  - SLT is signed; SLTU is unsigned.
  - SRA replicates a sign bit; shifts use only shamt.
  - LUI gives {b[WIDTH/2-1:0], zeros}.
  - Undefined alu_op gives result 0.
- Reset (asynchronous): state IDLE, hi = 0, lo = 0, md_busy = 0, md_done = 0, internal counters 0. Reset during RUN or FIX aborts the operation; no partial result reaches HI/LO.
- FSM states IDLE, RUN, FIX:
  - IDLE: md_start = 1 latches a, b, md_op and operand signs. Signed ops store magnitudes. Counter = WIDTH - 1. Go to RUN.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract, producing a quotient bit per cycle.
    - Counter == 0: go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse md_done, go to IDLE.
    - Multiply: negate the product if sign_a ^ sign_b.
    - Divide: quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
- Latency: md_start sampled at edge 0. md_busy is high from edge 0 through edge WIDTH+1. HI/LO update and md_done = 1 at edge WIDTH+1, so md_busy falls in the same cycle md_done rises (WIDTH+1 cycles total).
- HI/LO contents:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b == 0), DIV or DIVU: full latency, lo = all ones, hi = a (original, unsigned-magnitude-free).
- Signed overflow, DIV of MIN_INT by -1: lo = MIN_INT, hi = 0 (falls out of magnitude arithmetic; no trap).
- md_start while md_busy: ignored.
- hi_we/lo_we while md_busy: ignored. In IDLE they write on the edge.
- hi_we/lo_we in the same cycle as an accepted md_start: the MT write occurs, and the later md result overwrites it.
- md_done and hi_we/lo_we can never collide: MT writes are blocked while busy, and done occurs during busy.
- Operand inputs a and b may change after acceptance; internal copies are used.

Decomposition:
- Package mips_cpu_alu_pkg holds:
  - alu_op_t, md_op_t, md_state_t enums;
  - the decoder mapping of funct/opcode to alu_op_t.
- Sub-module mips_cpu_md_iter holds the FSM and the iterative datapath, with ports clk, reset, start, op, a, b, busy, done, hi_res, lo_res.
- The top keeps the combinational ALU and the HI/LO registers.

Test Plan:
- alu_op = SRA, b = 0x8000_00F0, shamt = 4 -> result 0xF800_000F; SLT a = 0xFFFF_FFFF, b = 1 -> 1; SLTU on the same operands -> 0, zero = 1.
- MULTU a = 0xFFFF_FFFF, b = 0xFFFF_FFFF -> after 33 cycles, md_done pulse, hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- MULT a = -7, b = 3 -> hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB; DIV a = -7, b = 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF.
- DIVU a = 100, b = 0 -> lo = 0xFFFF_FFFF, hi = 100; DIV a = 0x8000_0000, b = -1 -> lo = 0x8000_0000, hi = 0.
- Start MULTU 6 × 7, pulse md_start and hi_we again at cycle 5 -> both ignored; hi = 0, lo = 42, exactly one md_done.
- Assert reset at cycle 10 of a DIVU -> hi = lo = 0, md_busy = 0 immediately; a new DIVU 9 / 4 afterwards -> lo = 2, hi = 1.
